// File: rtl/lcd_capture_if.sv
// Panel-side video bus into lcd_capture and the captured-pixel bus out of it.
// The capture block is the slave; the panel/consumer side is the master.
interface lcd_capture_if;
    logic       vid_clk;
    logic       vid_hsync;
    logic       vid_vsync;
    logic       vid_den;
    logic [5:0] vid_red;
    logic [5:0] vid_green;
    logic [5:0] vid_blue;

    logic       pix_valid;
    logic [9:0] pix_x;
    logic [8:0] pix_y;
    logic [5:0] pix_red;
    logic [5:0] pix_green;
    logic [5:0] pix_blue;
    logic       frame_start;
    logic       line_end;
    logic       locked;
    logic       overflow;

    modport master (
        output vid_clk, vid_hsync, vid_vsync, vid_den, vid_red, vid_green, vid_blue,
        input  pix_valid, pix_x, pix_y, pix_red, pix_green, pix_blue,
        input  frame_start, line_end, locked, overflow
    );

    modport slave (
        input  vid_clk, vid_hsync, vid_vsync, vid_den, vid_red, vid_green, vid_blue,
        output pix_valid, pix_x, pix_y, pix_red, pix_green, pix_blue,
        output frame_start, line_end, locked, overflow
    );
endinterface

// File: rtl/lcd_capture.sv
// Samples an asynchronous RGB666 parallel panel bus into the CLOCK_50 domain and
// emits one strobe per active pixel with its column/row, plus frame health flags.
module lcd_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic         CLOCK_50,
    input  logic         rst_n,
    lcd_capture_if.slave vid
);
    localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
    localparam logic [9:0]  V_LIM = 10'(V_ACTIVE);

    typedef enum logic [1:0] {IDLE, FRAME, LINE} state_t;

    // Whole bus goes through one 2-flop synchronizer so a pixel event sees
    // clock, syncs and colour from the same stage-2 sample.
    logic [21:0] sync1, sync2;
    logic        clk_d;
    logic        pix_evt;
    logic        s_hs, s_vs, s_den;
    logic [17:0] s_rgb;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            clk_d <= 1'b0;
        end else begin
            sync1 <= {vid.vid_clk, vid.vid_hsync, vid.vid_vsync, vid.vid_den,
                      vid.vid_red, vid.vid_green, vid.vid_blue};
            sync2 <= sync1;
            clk_d <= sync2[21];
        end
    end

    assign pix_evt = sync2[21] & ~clk_d;
    assign s_hs    = sync2[20];
    assign s_vs    = sync2[19];
    assign s_den   = sync2[18];
    assign s_rgb   = sync2[17:0];

    state_t     state_q, state_n;
    logic [9:0] x_cnt;
    logic [8:0] y_cnt;
    logic       vs_prev, hs_prev, frame_bad;
    logic       vs_fall, hs_fall;
    logic       start_frame, end_line, take, abort;
    logic       in_range, line_full, frame_full;

    logic       pv, fs, le, lk, ov;
    logic [9:0] px;
    logic [8:0] py;
    logic [5:0] pr, pg, pb;

    // Sync edges are judged between consecutive pixel events, not CLOCK_50 cycles.
    assign vs_fall    = pix_evt & vs_prev & ~s_vs;
    assign hs_fall    = pix_evt & hs_prev & ~s_hs;
    assign in_range   = ({1'b0, x_cnt} < H_LIM) && ({1'b0, y_cnt} < V_LIM);
    assign line_full  = ({1'b0, x_cnt} == H_LIM);
    assign frame_full = ({1'b0, y_cnt} == V_LIM);

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_n;
    end

    // vsync always wins, so a coincident den fall never produces line_end.
    always_comb begin
        state_n     = state_q;
        start_frame = 1'b0;
        end_line    = 1'b0;
        take        = 1'b0;
        abort       = 1'b0;
        if (pix_evt) begin
            case (state_q)
                IDLE: begin
                    if (vs_fall) begin
                        state_n     = FRAME;
                        start_frame = 1'b1;
                    end
                end
                FRAME: begin
                    if (vs_fall) begin
                        start_frame = 1'b1;
                    end else if (s_den) begin
                        state_n = LINE;
                        take    = 1'b1;
                    end
                end
                LINE: begin
                    if (vs_fall) begin
                        state_n     = FRAME;
                        start_frame = 1'b1;
                        abort       = 1'b1;
                    end else if (!s_den || hs_fall) begin
                        state_n  = FRAME;
                        end_line = 1'b1;
                    end else begin
                        take = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev   <= 1'b0;
            hs_prev   <= 1'b0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            frame_bad <= 1'b0;
            pv        <= 1'b0;
            fs        <= 1'b0;
            le        <= 1'b0;
            lk        <= 1'b0;
            ov        <= 1'b0;
            px        <= '0;
            py        <= '0;
            pr        <= '0;
            pg        <= '0;
            pb        <= '0;
        end else begin
            pv <= 1'b0;
            fs <= 1'b0;
            le <= 1'b0;
            if (pix_evt) begin
                vs_prev <= s_vs;
                hs_prev <= s_hs;
            end
            if (start_frame) begin
                fs        <= 1'b1;
                lk        <= (state_q != IDLE) && !abort && !frame_bad && frame_full;
                ov        <= 1'b0;
                frame_bad <= 1'b0;
                x_cnt     <= '0;
                y_cnt     <= '0;
                px        <= '0;
                py        <= '0;
            end else if (end_line) begin
                le    <= 1'b1;
                x_cnt <= '0;
                y_cnt <= (y_cnt == 9'h1FF) ? y_cnt : y_cnt + 9'd1;
                if (!line_full) frame_bad <= 1'b1;
            end else if (take) begin
                x_cnt <= (x_cnt == 10'h3FF) ? x_cnt : x_cnt + 10'd1;
                if (in_range) begin
                    pv <= 1'b1;
                    px <= x_cnt;
                    py <= y_cnt;
                    pr <= s_rgb[17:12];
                    pg <= s_rgb[11:6];
                    pb <= s_rgb[5:0];
                end else begin
                    ov        <= 1'b1;
                    frame_bad <= 1'b1;
                end
            end
        end
    end

    assign vid.pix_valid   = pv;
    assign vid.pix_x       = px;
    assign vid.pix_y       = py;
    assign vid.pix_red     = pr;
    assign vid.pix_green   = pg;
    assign vid.pix_blue    = pb;
    assign vid.frame_start = fs;
    assign vid.line_end    = le;
    assign vid.locked      = lk;
    assign vid.overflow    = ov;
endmodule

// File: tb/tb_lcd_capture.sv
// Bench for lcd_capture on a scaled 16x6 panel: frames are described in a table,
// expected pixels come from the frame description and are compared in order.
module tb_lcd_capture;
    localparam int H = 16;
    localparam int V = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    lcd_capture_if bus();

    lcd_capture #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .CLOCK_50 (clk),
        .rst_n    (rst_n),
        .vid      (bus)
    );

    always #10 clk = ~clk;

    typedef struct {
        int nl;    // active rows sent
        int lng;   // row carrying H+1 den pixels (-1 none)
        int abl;   // row where vsync falls mid-line (-1 none)
        int abx;   // column of that vsync fall
        bit sim;   // vsync falls together with den on the last row
        int rsl;   // row before which rst_n is pulsed (-1 none)
        bit ramp;  // red = x, green = y
        bit lock;  // locked expected after this frame's vsync row
        bit ovf;   // overflow expected at the end of the frame
        int npix;  // pix_valid strobes in the frame
        int nle;   // line_end pulses in the frame
        int nfs;   // frame_start pulses in the frame
    } vec_t;

    int n_chk = 0, n_err = 0;
    int n_pix = 0, n_le = 0, n_fs = 0, n_both = 0;
    int rg = 0, re = 0;
    bit meas = 1'b0, m_cap = 1'b0;
    logic [36:0] got_q[$];
    logic [36:0] exp_q[$];

    always @(negedge clk) begin
        if (bus.pix_valid) begin
            got_q.push_back({bus.pix_x, bus.pix_y, bus.pix_red, bus.pix_green, bus.pix_blue});
            n_pix++;
        end
        if (bus.frame_start) n_fs++;
        if (bus.line_end) n_le++;
        if (bus.frame_start && bus.line_end) n_both++;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One panel pixel: data changes with the falling vid_clk, 2-3 cycles each phase.
    task automatic pix(input logic hs, input logic vs, input logic den, input logic [17:0] rgb);
        int lo, hi;
        lo = $urandom_range(3, 2);
        hi = $urandom_range(3, 2);
        bus.vid_clk   = 1'b0;
        bus.vid_hsync = hs;
        bus.vid_vsync = vs;
        bus.vid_den   = den;
        {bus.vid_red, bus.vid_green, bus.vid_blue} = rgb;
        repeat (lo) @(negedge clk);
        bus.vid_clk = 1'b1;
        if (meas && den) begin
            meas = 1'b0;
            repeat (2) @(negedge clk);
            chk("latency_edge2", bus.pix_valid, 0);
            @(negedge clk);
            chk("latency_edge3", bus.pix_valid, 1);
        end else begin
            repeat (hi) @(negedge clk);
        end
    endtask

    task automatic row(input logic vs, input int len, input int y, input bit ramp,
                       input int abx, input bit sim, output bit stop);
        int w, x;
        logic den;
        logic [17:0] rgb;
        logic [31:0] xv, yv;
        stop = 1'b0;
        w = (len + 6 > 20) ? len + 6 : 20;
        for (int c = 0; c < w; c++) begin
            x   = c - 4;
            den = (c >= 4) && (c < 4 + len);
            xv  = x;
            yv  = y;
            rgb = ramp ? {xv[5:0], yv[5:0], 6'($urandom)} : 18'($urandom);
            if ((den && x == abx) || (sim && c == 4 + len)) begin
                pix(1'b1, 1'b0, den, rgb);
                repeat (4) pix(1'b1, 1'b0, 1'b0, 18'd0);
                stop = 1'b1;
                return;
            end
            if (den && m_cap && x < H && y < V) exp_q.push_back({xv[9:0], yv[8:0], rgb});
            pix(c >= 2, vs, den, rgb);
        end
    endtask

    task automatic do_reset();
        #3 rst_n = 1'b0;
        #1;
        chk("reset_midframe_outputs",
            {bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_red, bus.pix_green, bus.pix_blue,
             bus.frame_start, bus.line_end, bus.locked, bus.overflow}, 0);
        m_cap = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic frame(input vec_t v, input int idx);
        int p0, l0, f0, n, k;
        bit stop;
        p0 = n_pix; l0 = n_le; f0 = n_fs;
        stop  = 1'b0;
        m_cap = 1'b1;
        row(1'b0, 0, 0, 1'b0, -1, 1'b0, stop);
        chk($sformatf("f%0d_locked", idx), bus.locked, v.lock);
        chk($sformatf("f%0d_overflow_cleared", idx), bus.overflow, 0);
        row(1'b1, 0, 0, 1'b0, -1, 1'b0, stop);
        for (int y = 0; y < v.nl && !stop; y++) begin
            if (y == v.rsl) do_reset();
            row(1'b1, (y == v.lng) ? H + 1 : H, y, v.ramp, (y == v.abl) ? v.abx : -1,
                v.sim && (y == v.nl - 1), stop);
        end
        if (!stop) row(1'b1, 0, 0, 1'b0, -1, 1'b0, stop);
        repeat (8) @(negedge clk);
        chk($sformatf("f%0d_pix_count", idx), n_pix - p0, v.npix);
        chk($sformatf("f%0d_line_end_count", idx), n_le - l0, v.nle);
        chk($sformatf("f%0d_frame_start_count", idx), n_fs - f0, v.nfs);
        chk($sformatf("f%0d_overflow_end", idx), bus.overflow, v.ovf);
        chk($sformatf("f%0d_stream_len", idx), got_q.size() - rg, exp_q.size() - re);
        n = got_q.size() - rg;
        if (exp_q.size() - re < n) n = exp_q.size() - re;
        if (n > 0) begin
            k = n - 1;
            for (int i = n - 1; i >= 0; i--)
                if (got_q[rg + i] != exp_q[re + i]) k = i;
            chk($sformatf("f%0d_pixel%0d_xyrgb", idx, k), got_q[rg + k], exp_q[re + k]);
        end
        rg = got_q.size();
        re = exp_q.size();
    endtask

    initial begin
        vec_t tv[17];
        bit stop;
        tv[0]  = '{6, -1, -1, -1, 1'b0, -1, 1'b1, 1'b0, 1'b0, 96, 6, 1};
        tv[1]  = '{6, -1, -1, -1, 1'b0, -1, 1'b0, 1'b1, 1'b0, 96, 6, 1};
        tv[2]  = '{6,  2, -1, -1, 1'b0, -1, 1'b0, 1'b1, 1'b1, 96, 6, 1};
        tv[3]  = '{6, -1, -1, -1, 1'b0, -1, 1'b1, 1'b0, 1'b0, 96, 6, 1};
        tv[4]  = '{5, -1, -1, -1, 1'b0, -1, 1'b0, 1'b1, 1'b0, 80, 5, 1};
        tv[5]  = '{6, -1, -1, -1, 1'b0, -1, 1'b0, 1'b0, 1'b0, 96, 6, 1};
        tv[6]  = '{7, -1, -1, -1, 1'b0, -1, 1'b0, 1'b1, 1'b1, 96, 7, 1};
        tv[7]  = '{6, -1, -1, -1, 1'b0, -1, 1'b0, 1'b0, 1'b0, 96, 6, 1};
        tv[8]  = '{6, -1,  3,  8, 1'b0, -1, 1'b0, 1'b1, 1'b0, 56, 3, 2};
        tv[9]  = '{6, -1, -1, -1, 1'b0, -1, 1'b1, 1'b0, 1'b0, 96, 6, 0};
        tv[10] = '{6, -1, -1, -1, 1'b0, -1, 1'b0, 1'b1, 1'b0, 96, 6, 1};
        tv[11] = '{6, -1, -1, -1, 1'b1, -1, 1'b0, 1'b1, 1'b0, 96, 5, 2};
        tv[12] = '{6, -1, -1, -1, 1'b0, -1, 1'b0, 1'b0, 1'b0, 96, 6, 0};
        tv[13] = '{6, -1, -1, -1, 1'b0, -1, 1'b1, 1'b1, 1'b0, 96, 6, 1};
        tv[14] = '{6, -1, -1, -1, 1'b0,  3, 1'b0, 1'b1, 1'b0, 48, 3, 1};
        tv[15] = '{6, -1, -1, -1, 1'b0, -1, 1'b1, 1'b0, 1'b0, 96, 6, 1};
        tv[16] = '{6, -1, -1, -1, 1'b0, -1, 1'b0, 1'b1, 1'b0, 96, 6, 1};

        bus.vid_clk   = 1'b0;
        bus.vid_hsync = 1'b1;
        bus.vid_vsync = 1'b1;
        bus.vid_den   = 1'b0;
        {bus.vid_red, bus.vid_green, bus.vid_blue} = 18'd0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_red, bus.pix_green, bus.pix_blue,
             bus.frame_start, bus.line_end, bus.locked, bus.overflow}, 0);
        rst_n = 1'b1;

        // den pixels before any vsync assertion must never be emitted
        row(1'b1, H, 0, 1'b0, -1, 1'b0, stop);
        repeat (8) @(negedge clk);
        chk("idle_pix_count", n_pix, 0);
        chk("idle_frame_start_count", n_fs, 0);

        meas = 1'b1;
        for (int i = 0; i < 17; i++) frame(tv[i], i);

        chk("latency_measured", meas, 0);
        chk("frame_start_line_end_overlap", n_both, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #20000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end
endmodule
